// File: rtl/icache_port_arbiter_if.sv
// icache_port_arbiter_if: request/response bundle shared by the demand
// requester, the auxiliary prefetcher and the icache/MMU port.
// master = arbiter view, slave = surrounding environment view.
interface icache_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic            dem_req_i;
    logic [XLEN-1:0] dem_addr_i;
    logic            dem_ack_o;
    logic [XLEN-1:0] dem_rdata_o;

    logic            aux_req_i;
    logic [XLEN-1:0] aux_addr_i;
    logic            aux_ack_o;
    logic [XLEN-1:0] aux_rdata_o;

    logic            flush_i;

    logic            mem_req_o;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_ack_i;
    logic [XLEN-1:0] mem_rdata_i;

    logic            busy_o;

    modport master (
        input  dem_req_i, dem_addr_i, aux_req_i, aux_addr_i, flush_i,
               mem_ack_i, mem_rdata_i,
        output dem_ack_o, dem_rdata_o, aux_ack_o, aux_rdata_o,
               mem_req_o, mem_addr_o, busy_o
    );

    modport slave (
        output dem_req_i, dem_addr_i, aux_req_i, aux_addr_i, flush_i,
               mem_ack_i, mem_rdata_i,
        input  dem_ack_o, dem_rdata_o, aux_ack_o, aux_rdata_o,
               mem_req_o, mem_addr_o, busy_o
    );
endinterface

// File: rtl/icache_port_arbiter.sv
// icache_port_arbiter: shares the single icache/MMU request port between the
// demand prefetch FIFO (dem, high priority) and the next-line prefetcher
// (aux, low priority). One transaction is outstanding at a time; a pipeline
// flush abandons a demand transaction but still waits out the memory ack.
// Optional macro ICACHE_ARB_STARVE_EN adds an anti-starvation counter that
// forces an aux grant after STARVE_LIMIT demand grants made while aux waited.
module icache_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic                   clk,
    input logic                   rst,
    icache_port_arbiter_if.master bus
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_BUSY_DEM = 2'd1;
    localparam logic [1:0] S_BUSY_AUX = 2'd2;
    localparam logic [1:0] S_DRAIN    = 2'd3;

    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("icache_port_arbiter: STARVE_LIMIT must be at least 1");
    end

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic            mem_req_q;
    logic [XLEN-1:0] mem_addr_q;
    logic            starve_override;
    logic            grant_dem;
    logic            grant_aux;

    // Grant decision is only made in IDLE; demand wins unless flushed or overridden.
    assign grant_dem = (state == S_IDLE) && bus.dem_req_i && !bus.flush_i && !starve_override;
    assign grant_aux = (state == S_IDLE) && !grant_dem && bus.aux_req_i;

`ifdef ICACHE_ARB_STARVE_EN
    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    assign starve_override = bus.aux_req_i && (starve_cnt == CNT_MAX);

    // Count demand grants that bypassed a waiting aux; any aux grant or idle aux clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_dem) begin
            if (!bus.aux_req_i) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else if (grant_aux) begin
            starve_cnt <= '0;
        end
    end
`else
    assign starve_override = 1'b0;
`endif

    // Transaction FSM: a flushed demand parks in DRAIN until memory answers.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_dem) begin
                    state_nxt = S_BUSY_DEM;
                end else if (grant_aux) begin
                    state_nxt = S_BUSY_AUX;
                end
            end
            S_BUSY_DEM: begin
                if (bus.mem_ack_i) begin
                    state_nxt = S_IDLE;
                end else if (bus.flush_i) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_BUSY_AUX: begin
                if (bus.mem_ack_i) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus.mem_ack_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State plus the registered memory request; the address stays latched after completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state     <= state_nxt;
            mem_req_q <= (state_nxt != S_IDLE);
            if (grant_dem) begin
                mem_addr_q <= bus.dem_addr_i;
            end else if (grant_aux) begin
                mem_addr_q <= bus.aux_addr_i;
            end
        end
    end

    assign bus.mem_req_o  = mem_req_q;
    assign bus.mem_addr_o = mem_addr_q;
    assign bus.busy_o     = (state != S_IDLE);

    // Responses are routed combinationally; a flush in the ack cycle kills the demand ack.
    assign bus.dem_ack_o   = (state == S_BUSY_DEM) && bus.mem_ack_i && !bus.flush_i;
    assign bus.aux_ack_o   = (state == S_BUSY_AUX) && bus.mem_ack_i;
    assign bus.dem_rdata_o = bus.dem_ack_o ? bus.mem_rdata_i : '0;
    assign bus.aux_rdata_o = bus.aux_ack_o ? bus.mem_rdata_i : '0;
endmodule
